// File: rtl/vs_bin_loader.sv
// Port-A sequencer for the var-state bram: LOAD streams one bin out through a 2-deep FIFO,
// STORE writes a streamed bin back. Bin b lives at addresses b*NUM_VARS_BIN+1 onwards.
module vs_bin_loader #(
  parameter int DATA_WIDTH   = 19,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_VARS_BIN = 8,
  parameter int BIN_WIDTH    = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_load,
  input  logic                  start_store,
  input  logic [BIN_WIDTH-1:0]  bin_index,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  vs_out_valid,
  input  logic                  vs_out_ready,
  output logic [DATA_WIDTH-1:0] vs_out_data,
  output logic                  vs_out_last,
  input  logic                  vs_in_valid,
  output logic                  vs_in_ready,
  input  logic [DATA_WIDTH-1:0] vs_in_data,
  output logic [2:0]            state_dbg
);

  // Handshakes: a word transfers on any cycle where valid && ready are both high; a source
  // holding valid keeps its data stable until it is accepted.

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD       = 3'd1;
  localparam logic [2:0] LOAD_DRAIN = 3'd2;
  localparam logic [2:0] STORE      = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;

  localparam int CW = $clog2(NUM_VARS_BIN + 1);
  localparam logic [CW-1:0] LAST_K = CW'(NUM_VARS_BIN - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CW-1:0]         rd_k;
  logic [CW-1:0]         out_k;
  logic [CW-1:0]         in_k;
  logic                  rd_pend;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;

  logic [1:0]            occ;
  logic                  issue;
  logic                  pop;
  logic                  pop_fifo;
  logic                  push;
  logic                  beat;
  logic [ADDR_WIDTH-1:0] start_base;

  // The word returning from the bram counts as FIFO content in its arrival cycle; it is
  // presented straight from bram_dout when the FIFO registers are empty.
  always_comb begin
    occ          = fifo_cnt + {1'b0, rd_pend};
    issue        = (state == LOAD) && (occ < 2'd2);
    vs_out_valid = (fifo_cnt != 2'd0) || rd_pend;
    vs_out_data  = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] : bram_dout;
    vs_out_last  = vs_out_valid && (out_k == LAST_K);
    pop          = vs_out_valid && vs_out_ready;
    pop_fifo     = pop && (fifo_cnt != 2'd0);
    push         = rd_pend && !(pop && (fifo_cnt == 2'd0));
    vs_in_ready  = (state == STORE);
    beat         = vs_in_ready && vs_in_valid;
    bram_we      = beat;
    bram_din     = beat ? vs_in_data : '0;
    if (issue)
      bram_addr = base + ADDR_WIDTH'(rd_k);
    else if (beat)
      bram_addr = base + ADDR_WIDTH'(in_k);
    else
      bram_addr = '0;
    busy       = (state == LOAD) || (state == LOAD_DRAIN) || (state == STORE);
    done       = (state == DONE);
    state_dbg  = state;
    start_base = ADDR_WIDTH'(bin_index) * ADDR_WIDTH'(NUM_VARS_BIN) + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      base        <= '0;
      rd_k        <= '0;
      out_k       <= '0;
      in_k        <= '0;
      rd_pend     <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      rd_pend <= issue;
      if (push) begin
        fifo_mem[wr_ptr] <= bram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_fifo)
        rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop_fifo};
      if (pop)
        out_k <= out_k + 1'b1;

      case (state)
        IDLE: begin
          if (start_load) begin
            state <= LOAD;
            base  <= start_base;
            rd_k  <= '0;
            out_k <= '0;
          end else if (start_store) begin
            state <= STORE;
            base  <= start_base;
            in_k  <= '0;
          end
        end
        LOAD: begin
          if (issue) begin
            rd_k <= rd_k + 1'b1;
            if (rd_k == LAST_K)
              state <= LOAD_DRAIN;
          end
        end
        LOAD_DRAIN: begin
          // Leave as soon as this cycle's pop empties everything, so done follows the last pop.
          if (occ == {1'b0, pop})
            state <= DONE;
        end
        STORE: begin
          if (beat) begin
            in_k <= in_k + 1'b1;
            if (in_k == LAST_K)
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
